tube_readout: RTL and testbench
===============================

Name: tube_readout

Overview:
- Event-window controller and readout stage for a bank of Tube timing channels.
- Drives the shared tube clear and gate-enable lines and opens a fixed-length counting window on each trigger.
- Snapshots every tube's 8-bit cycle count when the window closes.
- Streams the snapshot out as a framed byte packet over a valid/ready handshake toward the downstream serializer or FIFO.

Parameters:
- NUM_TUBES, 8, number of tube channels on clk_cyc_bus (1..32).
- WINDOW_CYC, 200, window length in clk cycles. Legal range 1..255, so a tube counter never wraps inside the window.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clr  input  1  asynchronous, active-low reset.
- trigger  input  1  event trigger. Level input; only a rising edge is used.
- clk_cyc_bus  input  NUM_TUBES*8  packed tube counts. Tube i occupies bits [8i+7:8i].
- tube_clr  output  1  clear to all tubes. Active-high.
- gate_enable  output  1  latch gate enable to all tubes.
- busy  output  1  high whenever state is not IDLE.
- out_data  output  8  packet byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte.
- out_last  output  1  marks the final byte of a packet.
- trig_dropped  output  8  count of triggers ignored while busy. Saturates at 255.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, tube_clr=1, gate_enable=0, busy=0.
  - out_valid=0, out_data=0, out_last=0.
  - seq=0, trig_dropped=0, trig_q=0.
  - Reset mid-operation aborts any window or packet; no partial packet resumes.
- Trigger detection:
  - trig_q registers trigger each cycle.
  - start = trigger & ~trig_q.
  - A trigger held high produces exactly one event.
- Outputs are Moore-decoded from the registered state, so they are glitch-free.
- States:
  - IDLE: tube_clr=1, gate_enable=0. On start: go to WINDOW, win_cnt<=0.
  - WINDOW: tube_clr=0, gate_enable=1.
    - win_cnt increments each cycle.
    - When win_cnt==WINDOW_CYC-1, go to CAPTURE.
    - WINDOW lasts exactly WINDOW_CYC cycles, so tubes see clr=0 on WINDOW_CYC rising edges.
  - CAPTURE (1 cycle): tube_clr=1, gate_enable=0.
    - On the exiting edge, register all NUM_TUBES counts into snap[] (pre-clear values), then go to SEND with idx<=0.
    - A never-hit tube snapshots WINDOW_CYC.
    - A hit tube snapshots the number of window cycles before its latch closed.
  - SEND: tube_clr=1, gate_enable=0, out_valid=1.
    - Byte order: idx0=HEADER, idx1=seq, idx2..NUM_TUBES+1 = snap[0..NUM_TUBES-1].
    - out_last=1 only at idx=NUM_TUBES+1.
    - idx advances only on out_valid & out_ready.
    - While out_valid & ~out_ready, out_data and out_last hold stable.
    - On acceptance of the last byte: go to IDLE, out_valid=0 the next cycle, seq<=seq+1 (wraps 255->0).
- Packet length = NUM_TUBES+2 bytes.
- Minimum event-to-event spacing = WINDOW_CYC + 1 + (NUM_TUBES+2) cycles plus 1 IDLE cycle.
- start while state≠IDLE: event ignored, trig_dropped increments and saturates at 255. Capture and packet are unaffected.
- start in the same cycle as return to IDLE (last byte accepted): counted as dropped. The FSM is not yet in IDLE.
- out_ready high with out_valid low has no effect.

Test Plan:
- Reset: hold clr=0 with trigger and out_ready toggling -> tube_clr=1, gate_enable=0, out_valid=0, busy=0, trig_dropped=0 throughout. All outputs remain so after release until a trigger arrives.
- No hits (NUM_TUBES=4, WINDOW_CYC=100, Tube models with tubePin=0, out_ready=1): one trigger pulse -> gate_enable high exactly 100 cycles. Packet = A5,00,64,64,64,64 with out_last only on the 6th byte; busy falls after it.
- Single hit: tube 2's tubePin pulses during window cycle 37 -> its byte = 0x25 (±1 per the Tube latch edge, pinned in the bench model). Others = 0x64; seq byte = 0x01 on this second event.
- Backpressure: out_ready follows the pattern 1,0,0,1,0,1… -> each byte is held stable while stalled. Six bytes total, no duplicates or losses, correct order.
- Dropped triggers: trigger rises twice during WINDOW and once during SEND; trigger held high 500 cycles -> one packet only, trig_dropped=3. Drive 300 further overlapping triggers -> trig_dropped saturates at 0xFF.
- Abort and wrap: assert clr mid-SEND at idx=3 -> out_valid drops immediately, tube_clr=1, next packet seq=00. Run 257 events -> seq bytes go …FE,FF,00.

Source files
------------

// File: rtl/tube_readout_if.sv
// Byte stream from the tube readout toward the downstream serializer/FIFO.
// A byte transfers on every rising edge where out_valid and out_ready are both high;
// while out_valid is high and out_ready low, out_data and out_last hold stable.
interface tube_readout_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/tube_readout.sv
// Event-window controller for a bank of tube timing channels: opens a counting window
// per trigger, snapshots every tube count and streams it out as a framed byte packet.
module tube_readout #(
  parameter int         NUM_TUBES  = 8,
  parameter int         WINDOW_CYC = 200,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   trigger,
  input  logic [NUM_TUBES*8-1:0] clk_cyc_bus,
  output logic                   tube_clr,
  output logic                   gate_enable,
  output logic                   busy,
  output logic [7:0]             trig_dropped,
  output logic [1:0]             dbg_state,
  tube_readout_if.master         out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WINDOW  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_SEND    = 2'd3;

  localparam int               IDX_W    = $clog2(NUM_TUBES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TUBES + 1);
  localparam logic [7:0]       WIN_LAST = 8'(WINDOW_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       drop_q, drop_d;
  logic             trig_q;
  logic             start;
  logic [7:0]       snap_q [NUM_TUBES];
  logic [7:0]       pkt_byte;

  assign start = trigger & ~trig_q;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    drop_d    = drop_q;
    // Any rising trigger outside IDLE is lost, including on the last-byte edge.
    if (start && (state_q != S_IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WINDOW;
          win_cnt_d = '0;
        end
      end
      S_WINDOW: begin
        win_cnt_d = win_cnt_q + 8'd1;
        if (win_cnt_q == WIN_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_SEND;
        idx_d   = '0;
      end
      S_SEND: begin
        if (out.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            seq_d   = seq_q + 8'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      win_cnt_q <= '0;
      idx_q     <= '0;
      seq_q     <= '0;
      drop_q    <= '0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      trig_q    <= trigger;
    end
  end

  // Tubes are still cleared by this same edge, so the bus holds pre-clear counts.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE) begin
      for (int i = 0; i < NUM_TUBES; i++) snap_q[i] <= clk_cyc_bus[8*i +: 8];
    end
  end

  always_comb begin
    pkt_byte = 8'h00;
    if (idx_q == '0) begin
      pkt_byte = HEADER;
    end else if (idx_q == IDX_W'(1)) begin
      pkt_byte = seq_q;
    end else begin
      for (int i = 0; i < NUM_TUBES; i++) begin
        if (int'(idx_q) == i + 2) pkt_byte = snap_q[i];
      end
    end
  end

  assign tube_clr      = (state_q != S_WINDOW);
  assign gate_enable   = (state_q == S_WINDOW);
  assign busy          = (state_q != S_IDLE);
  assign trig_dropped  = drop_q;
  assign dbg_state     = state_q;
  assign out.out_valid = (state_q == S_SEND);
  assign out.out_data  = (state_q == S_SEND) ? pkt_byte : 8'h00;
  assign out.out_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_tube_readout.sv
// Randomized bench for tube_readout: behavioural tube models on the bus, an event-level
// reference model that predicts each packet from its hit plan, and a byte scoreboard.
module tb_tube_readout;
  localparam int NT = 4;
  localparam int W  = 100;

  logic          clk;
  logic          clr;
  logic          trigger;
  logic [NT*8-1:0] cyc_bus;
  logic          tube_clr, gate_enable, busy;
  logic [7:0]    trig_dropped;
  logic [1:0]    dbg_state;

  tube_readout_if bus ();

  tube_readout #(.NUM_TUBES(NT), .WINDOW_CYC(W), .HEADER(8'hA5)) dut (
    .clk          (clk),
    .clr          (clr),
    .trigger      (trigger),
    .clk_cyc_bus  (cyc_bus),
    .tube_clr     (tube_clr),
    .gate_enable  (gate_enable),
    .busy         (busy),
    .trig_dropped (trig_dropped),
    .dbg_state    (dbg_state),
    .out          (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- tube models ----------------
  // A tube counts gated cycles until its pin is seen high; that edge latches it without counting.
  logic [7:0]    tube_cnt [NT];
  logic [NT-1:0] tube_lat;
  logic [NT-1:0] tube_pin;

  always @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (tube_clr) begin
        tube_cnt[i] <= 8'h00;
        tube_lat[i] <= 1'b0;
      end else if (gate_enable && !tube_lat[i]) begin
        if (tube_pin[i]) tube_lat[i] <= 1'b1;
        else             tube_cnt[i] <= tube_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    cyc_bus = '0;
    for (int i = 0; i < NT; i++) cyc_bus[8*i +: 8] = tube_cnt[i];
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];   // {last, byte}
  bit   m_active;
  int   m_age;            // cycles since the accepting edge
  int   m_drop;
  int   m_seq;
  int   m_popped;
  bit   m_prev_trig;
  int   m_hit    [NT];    // window cycle of the hit, -1 = never hit
  int   next_hit [NT];

  bit   trig_lvl;
  bit   clr_next;
  int   rdy_mode;         // 0 always ready, 1 fixed pattern, 2 random
  int   pat_i;
  bit   prev_stall;
  logic [7:0] prev_data;
  logic prev_last;
  logic [5:0] rdy_pat;

  task automatic model_reset();
    exp_q.delete();
    m_active = 0; m_age = 0; m_drop = 0; m_seq = 0; m_popped = 0;
    m_prev_trig = 0; prev_stall = 0;
  endtask

  task automatic model_update(input bit rdy);
    bit start;
    bit last;
    int v;
    start = trig_lvl && !m_prev_trig;
    m_prev_trig = trig_lvl;
    if (m_active) begin
      if (start && m_drop < 255) m_drop++;
      if (m_age > W && rdy) begin
        last = exp_q[0][8];
        void'(exp_q.pop_front());
        m_popped++;
        if (last) begin
          m_active = 0;
          m_seq = (m_seq + 1) % 256;
        end
      end
      if (m_age <= W) m_age++;
    end else if (start) begin
      m_active = 1; m_age = 0; m_popped = 0;
      m_hit = next_hit;
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b0, 8'(m_seq)});
      for (int i = 0; i < NT; i++) begin
        v = (m_hit[i] < 0) ? W : m_hit[i];
        exp_q.push_back({(i == NT - 1), 8'(v)});
      end
    end
  endtask

  // ---------------- driver: one cycle ----------------
  task automatic step();
    bit exp_gate;
    bit exp_valid;
    bit rdy;
    @(negedge clk);
    exp_gate  = m_active && (m_age < W);
    exp_valid = m_active && (m_age > W);
    chk("busy", busy, m_active);
    chk("gate_enable", gate_enable, exp_gate);
    chk("tube_clr", tube_clr, !exp_gate);
    chk("out_valid", bus.out_valid, exp_valid);
    chk("trig_dropped", trig_dropped, m_drop);
    if (exp_valid && exp_q.size() > 0) begin
      chk("out_data", bus.out_data, exp_q[0][7:0]);
      chk("out_last", bus.out_last, exp_q[0][8]);
    end else begin
      chk("out_last_idle", bus.out_last, 1'b0);
    end
    if (!clr) chk("rst_out_data", bus.out_data, 8'h00);
    if (prev_stall) begin
      chk("hold_data", bus.out_data, prev_data);
      chk("hold_last", bus.out_last, prev_last);
    end

    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = rdy_pat[5 - (pat_i % 6)];
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    pat_i++;
    bus.out_ready = rdy;
    trigger = trig_lvl;
    for (int i = 0; i < NT; i++) tube_pin[i] = m_active && (m_age < W) && (m_hit[i] == m_age);
    prev_stall = bus.out_valid && !rdy;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
    clr = clr_next;
    if (!clr) model_reset();
    else      model_update(rdy);
  endtask

  task automatic fire();
    trig_lvl = 1'b1;
    step();
    trig_lvl = 1'b0;
    step();
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!m_active) return;
      step();
    end
    chk("idle_timeout", m_active, 1'b0);
  endtask

  task automatic rand_hits();
    for (int i = 0; i < NT; i++)
      next_hit[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rdy_pat = 6'b100101;
    pat_i = 0;
    clr = 1'b0; clr_next = 1'b0;
    trigger = 1'b0; trig_lvl = 1'b0;
    bus.out_ready = 1'b0;
    tube_pin = '0;
    for (int i = 0; i < NT; i++) begin
      tube_cnt[i] = 8'h00;
      next_hit[i] = -1;
      m_hit[i] = -1;
    end
    tube_lat = '0;
    model_reset();

    // reset held with inputs toggling
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) begin
      trig_lvl = $urandom_range(0, 1) == 1;
      step();
    end
    trig_lvl = 1'b0;
    step();
    clr_next = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) step();

    // no hits: A5,00,64,64,64,64
    for (int i = 0; i < NT; i++) next_hit[i] = -1;
    fire();
    wait_idle(400);

    // single hit on tube 2 in window cycle 37
    for (int i = 0; i < NT; i++) next_hit[i] = -1;
    next_hit[2] = 37;
    fire();
    wait_idle(400);
    step();

    // backpressure pattern
    rdy_mode = 1;
    rand_hits();
    fire();
    wait_idle(600);
    rdy_mode = 0;
    step();

    // dropped triggers: two during WINDOW, one during SEND
    rand_hits();
    fire();
    for (int i = 0; i < 10; i++) step();
    fire();
    for (int i = 0; i < 10; i++) step();
    fire();
    for (int i = 0; i < 400 && !(m_active && m_age > W); i++) step();
    fire();
    wait_idle(400);
    chk("drop_three", trig_dropped, 8'd3);

    // trigger held high for 500 cycles gives a single packet
    rand_hits();
    trig_lvl = 1'b1;
    for (int i = 0; i < 500; i++) step();
    trig_lvl = 1'b0;
    wait_idle(400);
    chk("drop_held", trig_dropped, 8'd3);

    // many overlapping triggers saturate the drop counter
    for (int i = 0; i < 300; i++) begin
      rand_hits();
      fire();
    end
    wait_idle(400);
    chk("drop_sat", trig_dropped, 8'hFF);
    step();

    // abort mid-SEND at idx 3
    rand_hits();
    fire();
    for (int i = 0; i < 400 && m_popped < 3; i++) step();
    clr_next = 1'b0;
    step();
    #1;
    chk("abort_valid", bus.out_valid, 1'b0);
    chk("abort_tube_clr", tube_clr, 1'b1);
    chk("abort_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) step();
    clr_next = 1'b1;
    step();
    step();
    rand_hits();
    fire();
    wait_idle(400);

    // long random run wrapping the sequence byte
    rdy_mode = 2;
    for (int e = 0; e < 257; e++) begin
      rand_hits();
      fire();
      wait_idle(1000);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
